mem_copy_engine: RTL



---
 rtl/mem_copy_engine.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_copy_engine.sv
// mem_copy_engine
// ---------------
// Block-copy initiator for a single-clock synchronous RAM with a registered
// read (1-cycle latency) and a synchronous write. A start pulse copies len
// words from src to dst, one word per cycle: the read of word N is issued in
// the same cycle as the write of word N-1, which comes from the RAM's dout.
// When dst > src the copy runs descending so that overlapping moves are safe.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 begin a copy (sampled only while idle)
//   src, dst, len         first source/destination address, word count
//   busy                  copy in progress (READ and DRAIN states)
//   done                  one-cycle completion pulse
//   read_address          to RAM read port
//   write_address, write  to RAM write port
//   din                   to RAM din, wired straight from dout
//   dout                  from RAM, word read at the previous edge

module mem_copy_engine #(
   parameter int data_width = 32,
   parameter int addr_width = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [addr_width-1:0] src,
   input  logic [addr_width-1:0] dst,
   input  logic [addr_width:0]   len,
   output logic                  busy,
   output logic                  done,
   output logic [addr_width-1:0] read_address,
   output logic [addr_width-1:0] write_address,
   output logic                  write,
   output logic [data_width-1:0] din,
   input  logic [data_width-1:0] dout
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   localparam logic [addr_width-1:0] one_a = addr_width'(1);

   state_t                state_q, state_d;
   logic [addr_width-1:0] rp_q, rp_d;        // next address to read
   logic [addr_width-1:0] wp_q, wp_d;        // next address to write
   logic [addr_width-1:0] cnt_q, cnt_d;      // reads still to issue after the current one
   logic                  desc_q, desc_d;    // 1 = descending copy
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  write_q, write_d;
   logic [addr_width-1:0] rd_addr_q, rd_addr_d;
   logic [addr_width-1:0] wr_addr_q, wr_addr_d;

   logic                  start_desc;
   logic [addr_width-1:0] len_m1;
   logic [addr_width-1:0] first_rp;
   logic [addr_width-1:0] first_wp;

   // Start-time pointer setup. len = 2**addr_width truncates to 0 in
   // addr_width bits, so len_m1 still lands on the last word (modulo depth).
   assign start_desc = (dst > src);
   assign len_m1     = len[addr_width-1:0] - one_a;
   assign first_rp   = start_desc ? src + len_m1 : src;
   assign first_wp   = start_desc ? dst + len_m1 : dst;

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      rp_d      = rp_q;
      wp_d      = wp_q;
      cnt_d     = cnt_q;
      desc_d    = desc_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      write_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (len == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d   = READ;
                  busy_d    = 1'b1;
                  desc_d    = start_desc;
                  rd_addr_d = first_rp;
                  rp_d      = start_desc ? first_rp - one_a : first_rp + one_a;
                  wp_d      = first_wp;
                  cnt_d     = len_m1;
               end
            end
         end

         READ: begin
            // The word read this cycle appears on dout next cycle, so the
            // write for it is scheduled now.
            write_d   = 1'b1;
            wr_addr_d = wp_q;
            wp_d      = desc_q ? wp_q - one_a : wp_q + one_a;
            if (cnt_q == '0) begin
               state_d = DRAIN;
            end else begin
               rd_addr_d = rp_q;
               rp_d      = desc_q ? rp_q - one_a : rp_q + one_a;
               cnt_d     = cnt_q - one_a;
            end
         end

         DRAIN: begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         rp_q      <= '0;
         wp_q      <= '0;
         cnt_q     <= '0;
         desc_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         write_q   <= 1'b0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         rp_q      <= rp_d;
         wp_q      <= wp_d;
         cnt_q     <= cnt_d;
         desc_q    <= desc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         write_q   <= write_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign write         = write_q;
   assign read_address  = rd_addr_q;
   assign write_address = wr_addr_q;
   assign din           = dout;

endmodule
